apb_ram_responder: RTL

APB responder fronting a word-organised, byte-writable RAM. It is the far end of the CPU's APB initiator port, and serves instruction fetches, loads and stores from the core. Wait states are configurable, `APB_pstb` sets the write byte lanes, and out-of-range or misaligned accesses are reported on `APB_perr`.

---
 rtl/apb_pkg.sv | 22 ++
 rtl/apb_ram_responder_if.sv | 27 ++
 rtl/apb_ram_responder_ram.sv | 38 +++
 rtl/apb_ram_responder.sv | 122 ++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared definitions for the APB RAM responder: FSM states, bus constants
// and the address-error decode used at setup time.
package apb_pkg;

   typedef enum logic [0:0] {
      ST_IDLE   = 1'b0,
      ST_ACCESS = 1'b1
   } apb_state_e;

   localparam int unsigned APB_STB_W      = 4;
   localparam int unsigned APB_WORD_BYTES = 4;

   // Misaligned, or outside [base, base + 4*depth); addresses below base wrap high.
   function automatic logic apb_addr_err(input logic [31:0] addr,
                                         input logic [31:0] base,
                                         input logic [31:0] depth);
      logic [31:0] word_off;
      word_off = (addr - base) >> 2;
      return (addr[1:0] != 2'b00) || (word_off >= depth);
   endfunction

endpackage

// File: rtl/apb_ram_responder_if.sv
// APB bus bundle between the CPU initiator (master) and the RAM responder (slave).
interface apb_ram_responder_if
   import apb_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32
);
   logic [ADDR_WIDTH-1:0] APB_paddr;
   logic [DATA_WIDTH-1:0] APB_pdata;
   logic [DATA_WIDTH-1:0] APB_prdata;
   logic                  APB_psel;
   logic                  APB_penable;
   logic                  APB_pwrite;
   logic [APB_STB_W-1:0]  APB_pstb;
   logic                  APB_pready;
   logic                  APB_perr;

   modport master (
      output APB_paddr, APB_pdata, APB_psel, APB_penable, APB_pwrite, APB_pstb,
      input  APB_prdata, APB_pready, APB_perr
   );

   modport slave (
      input  APB_paddr, APB_pdata, APB_psel, APB_penable, APB_pwrite, APB_pstb,
      output APB_prdata, APB_pready, APB_perr
   );
endinterface

// File: rtl/apb_ram_responder_ram.sv
// Single-port word RAM with per-byte write enables and a registered read port.
module ram_array
   import apb_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter int unsigned IDX_W       = $clog2(DEPTH_WORDS)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 re_i,
   input  logic [APB_STB_W-1:0] we_i,
   input  logic [IDX_W-1:0]     addr_i,
   input  logic [31:0]          wdata_i,
   output logic [31:0]          rdata_o
);

   logic [31:0] mem_q [DEPTH_WORDS];
   logic [31:0] rdata_q;

   // NOTE: the array has no reset; clearing it would turn the RAM into flops and contents must survive reset anyway.
   always_ff @(posedge clk) begin
      for (int b = 0; b < int'(APB_WORD_BYTES); b++) begin
         if (we_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
   end

   // NOTE: non-blocking assignments here so every flop samples pre-edge values, whatever the block order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata_q <= '0;
      end else if (re_i) begin
         rdata_q <= mem_q[addr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/apb_ram_responder.sv
// APB responder in front of a byte-writable word RAM: setup latches the request
// and starts the RAM read, access waits WAIT_STATES cycles and then completes.
module apb_ram_responder
   import apb_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH  = 32,
   parameter int unsigned DATA_WIDTH  = 32,
   parameter logic [31:0] BASE_ADDR   = 32'h0,
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter int unsigned WAIT_STATES = 0
) (
   input logic                APB_PCLK,
   input logic                APB_PRESETn,
   apb_ram_responder_if.slave apb
);

   localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
   localparam logic [3:0]  WS    = 4'(WAIT_STATES);

   apb_state_e            state_q, state_d;
   logic [3:0]            cnt_q, cnt_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic                  pwrite_q, pwrite_d;
   logic [APB_STB_W-1:0]  pstb_q, pstb_d;
   logic [DATA_WIDTH-1:0] pdata_q, pdata_d;
   logic                  err_q, err_d;

   logic [ADDR_WIDTH-1:0] paddr;
   logic [31:0]           paddr32;
   logic [31:0]           word_off;
   logic [IDX_W-1:0]      idx_now;
   logic                  err_now;
   logic                  setup, proto_err, done;
   logic [IDX_W-1:0]      ram_addr;
   logic [APB_STB_W-1:0]  ram_we;
   logic [31:0]           ram_rdata;

   assign paddr    = apb.APB_paddr;
   assign paddr32  = 32'(paddr);
   assign word_off = (paddr32 - BASE_ADDR) >> 2;
   assign idx_now  = IDX_W'(word_off);
   assign err_now  = apb_addr_err(paddr32, BASE_ADDR, 32'(DEPTH_WORDS));

   assign setup     = (state_q == ST_IDLE)   &  apb.APB_psel & ~apb.APB_penable;
   assign proto_err = (state_q == ST_IDLE)   &  apb.APB_psel &  apb.APB_penable;
   assign done      = (state_q == ST_ACCESS) &  apb.APB_psel &  apb.APB_penable & (cnt_q == WS);

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      idx_d    = idx_q;
      pwrite_d = pwrite_q;
      pstb_d   = pstb_q;
      pdata_d  = pdata_q;
      err_d    = err_q;
      case (state_q)
         ST_IDLE: begin
            if (setup) begin
               state_d  = ST_ACCESS;
               cnt_d    = '0;
               idx_d    = idx_now;
               pwrite_d = apb.APB_pwrite;
               pstb_d   = apb.APB_pstb;
               pdata_d  = apb.APB_pdata;
               err_d    = err_now;
            end
         end
         ST_ACCESS: begin
            if (!apb.APB_psel || done) begin
               state_d = ST_IDLE;
            end else if (cnt_q != WS) begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge APB_PCLK or negedge APB_PRESETn) begin
      if (!APB_PRESETn) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         idx_q    <= '0;
         pwrite_q <= 1'b0;
         pstb_q   <= '0;
         pdata_q  <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         idx_q    <= idx_d;
         pwrite_q <= pwrite_d;
         pstb_q   <= pstb_d;
         pdata_q  <= pdata_d;
         err_q    <= err_d;
      end
   end

   // The read address comes straight off the bus at setup; writes use the latched index.
   assign ram_addr = setup ? idx_now : idx_q;
   assign ram_we   = pstb_q & {APB_STB_W{done & pwrite_q & ~err_q}};

   ram_array #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .IDX_W       (IDX_W)
   ) u_ram (
      .clk     (APB_PCLK),
      .rst_n   (APB_PRESETn),
      .re_i    (setup),
      .we_i    (ram_we),
      .addr_i  (ram_addr),
      .wdata_i (32'(pdata_q)),
      .rdata_o (ram_rdata)
   );

   // Reset masks the combinational responses too, even if the bus still shows psel & penable.
   assign apb.APB_pready = APB_PRESETn & (done | proto_err);
   assign apb.APB_perr   = APB_PRESETn & ((done & err_q) | proto_err);
   assign apb.APB_prdata = err_q ? '0 : DATA_WIDTH'(ram_rdata);

endmodule
